program_counter_8b: RTL and testbench

8-bit program counter for the 8-bit microprocessor datapath. It holds the address of the next instruction. It increments by one per enabled clock and accepts a parallel load for jumps and branches. It drives the instruction-memory address bus and takes its load value from the control unit or immediate/operand path.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/program_counter_8b_if.sv | 29 ++
 rtl/pc_next_mux.sv | 24 ++
 rtl/program_counter_8b.sv | 37 +++
 tb/tb_program_counter_8b.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU address types, common to the PC, instruction memory and control unit.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/program_counter_8b_if.sv
// Control-side bus of the program counter: load/enable strobes, load value and PC output.
interface program_counter_8b_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W
);

  logic             ld;
  logic             pc_enable;
  logic [WIDTH-1:0] inp;
  logic [WIDTH-1:0] out;

  // Control unit side: drives the strobes and load value, observes the PC.
  modport master (
    output ld,
    output pc_enable,
    output inp,
    input  out
  );

  // Program counter side.
  modport slave (
    input  ld,
    input  pc_enable,
    input  inp,
    output out
  );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC selection: load beats increment beats hold.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W
) (
  input  logic [WIDTH-1:0] pc_q,
  input  logic             ld,
  input  logic             pc_enable,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] pc_next_c
);

  // Loaded value is taken as-is; no increment is applied on the load edge.
  always_comb begin
    pc_next_c = pc_q;
    if (ld) begin
      pc_next_c = inp;
    end else if (pc_enable) begin
      pc_next_c = pc_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_counter_8b.sv
// Program counter: async active-low reset register fed by pc_next_mux; out is the register.
module program_counter_8b
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH       = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  program_counter_8b_if.slave   bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  pc_next_mux #(
    .WIDTH (WIDTH)
  ) u_pc_next_mux (
    .pc_q      (pc_q),
    .ld        (bus.ld),
    .pc_enable (bus.pc_enable),
    .inp       (bus.inp),
    .pc_next_c (pc_d)
  );

  // PC register; reset takes effect immediately and discards any pending update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.out = pc_q;

endmodule

// File: tb/tb_program_counter_8b.sv
// Directed table-driven bench for program_counter_8b with a reference-model random tail.
module tb_program_counter_8b;
  import cpu_pkg::*;

  localparam addr_t RST_VAL = 8'h00;

  typedef struct {
    logic  ld;
    logic  en;
    addr_t inp;
    addr_t exp;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[$];
  addr_t model;

  program_counter_8b_if #(.WIDTH(ADDR_W)) bus_if ();

  program_counter_8b #(
    .WIDTH       (ADDR_W),
    .RESET_VALUE (RST_VAL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic addr_t pc_model(addr_t pc, logic ld, logic en, addr_t inp);
    if (ld) return inp;
    if (en) return addr_t'(pc + 8'd1);
    return pc;
  endfunction

  task automatic check(input string name, input addr_t act, input addr_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: out=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic en, input addr_t inp);
    bus_if.ld        = ld;
    bus_if.pc_enable = en;
    bus_if.inp       = inp;
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Protocol properties, checked whenever reset is released.
  property p_reset_val;
    @(posedge clk) !reset |-> bus_if.out == RST_VAL;
  endproperty
  property p_load;
    @(posedge clk) disable iff (!reset) bus_if.ld |=> bus_if.out == $past(bus_if.inp);
  endproperty
  property p_count;
    @(posedge clk) disable iff (!reset)
      (bus_if.pc_enable && !bus_if.ld) |=> bus_if.out == addr_t'($past(bus_if.out) + 8'd1);
  endproperty
  property p_hold;
    @(posedge clk) disable iff (!reset)
      (!bus_if.pc_enable && !bus_if.ld) |=> $stable(bus_if.out);
  endproperty
  property p_no_x;
    @(posedge clk) disable iff (!reset) !$isunknown({bus_if.ld, bus_if.pc_enable});
  endproperty

  a_reset_val: assert property (p_reset_val) else $error("FAIL sva_reset out=%h", bus_if.out);
  a_load:      assert property (p_load)      else $error("FAIL sva_load out=%h", bus_if.out);
  a_count:     assert property (p_count)     else $error("FAIL sva_count out=%h", bus_if.out);
  a_hold:      assert property (p_hold)      else $error("FAIL sva_hold out=%h", bus_if.out);
  a_no_x:      assert property (p_no_x)      else $error("FAIL sva_no_x ld=%b en=%b", bus_if.ld, bus_if.pc_enable);

  initial begin
    total = 0;
    bad   = 0;

    // Reset asserted from time zero; strobes must be ignored while it is held.
    reset = 1'b0;
    drive(1'b0, 1'b1, 8'h00);
    #1;
    check("reset_async", bus_if.out, 8'h00);
    step();
    check("reset_held", bus_if.out, 8'h00);

    // Release mid-cycle, then walk the directed table.
    drive(1'b0, 1'b0, 8'h00);
    reset = 1'b1;

    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h01});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h02});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h03});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h04});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h05});
    vecs.push_back('{1'b1, 1'b0, 8'h18, 8'h18});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h19});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h1A});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h1B});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h1B});
    vecs.push_back('{1'b0, 1'b0, 8'h55, 8'h1B});
    vecs.push_back('{1'b1, 1'b0, 8'hFE, 8'hFE});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'hFF});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h01});
    vecs.push_back('{1'b1, 1'b1, 8'h40, 8'h40});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ld, vecs[i].en, vecs[i].inp);
      step();
      check($sformatf("vec%0d", i), bus_if.out, vecs[i].exp);
    end

    // Async reset while counting at 1B.
    drive(1'b1, 1'b0, 8'h1B);
    step();
    check("load_1b", bus_if.out, 8'h1B);
    drive(1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst_mid_cycle", bus_if.out, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("rst_hold%0d", i), bus_if.out, 8'h00);
    end
    #3;
    reset = 1'b1;
    step();
    check("first_after_release", bus_if.out, 8'h01);

    // Random traffic scored against the reference model.
    model = 8'h01;
    for (int i = 0; i < 40; i++) begin
      logic  r_ld;
      logic  r_en;
      addr_t r_inp;
      r_ld  = ($urandom_range(0, 3) == 0);
      r_en  = 1'($urandom_range(0, 1));
      r_inp = addr_t'($urandom);
      drive(r_ld, r_en, r_inp);
      model = pc_model(model, r_ld, r_en, r_inp);
      step();
      check($sformatf("rand%0d", i), bus_if.out, model);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
